// File: rtl/seq_pattern_tx_if.sv
// Handshake/stream bundle for the serial pattern transmitter.
// master drives the request side, slave is the transmitter itself.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] rep_count;
  logic             x;
  logic             valid;
  logic             frame_end;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, rep_count,
    input  x, valid, frame_end, busy, done
  );

  modport slave (
    input  start, pattern, rep_count,
    output x, valid, frame_end, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, rep_count times,
// with GAP idle cycles between copies. All outputs come straight from flops.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic           clk,
  input  logic           reset,
  seq_pattern_tx_if.slave bus
);

  localparam int BW = $clog2(PAT_W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_lat;
  logic [PAT_W-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] rem;
  logic [GW-1:0]    gap_cnt;
  logic             x_q, valid_q, fe_q, busy_q, done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pat_lat <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      rem     <= '0;
      gap_cnt <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pat_lat <= bus.pattern;
            shreg   <= bus.pattern;
            bit_cnt <= '0;
            rem     <= bus.rep_count;
            if (bus.rep_count != '0) begin
              state   <= S_SEND;
              x_q     <= bus.pattern[PAT_W-1];
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (bit_cnt == LAST_BIT) begin
            // Last bit of a copy is on the wire: account for it and reload.
            rem     <= rem - 1'b1;
            fe_q    <= 1'b0;
            bit_cnt <= '0;
            shreg   <= pat_lat;
            if (rem == CNT_W'(1)) begin
              state   <= S_DONE;
              x_q     <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= '0;
              x_q     <= 1'b0;
              valid_q <= 1'b0;
            end else begin
              x_q <= pat_lat[PAT_W-1];
            end
          end else begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
            x_q     <= shreg[PAT_W-2];
            fe_q    <= (bit_cnt == LAST_BIT - 1'b1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP - 1)) begin
            state   <= S_SEND;
            x_q     <= shreg[PAT_W-1];
            valid_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.x         = x_q;
  assign bus.valid     = valid_q;
  assign bus.frame_end = fe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx (PAT_W=4, CNT_W=4, GAP=1).
// Observed vector per cycle is {x, valid, frame_end, busy, done}.
module tb_seq_pattern_tx;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  seq_pattern_tx_if #(.PAT_W(4), .CNT_W(4)) ifc ();

  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {ifc.x, ifc.valid, ifc.frame_end, ifc.busy, ifc.done};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ifc.start = 1'b1;
    ifc.pattern = 4'b1011;
    ifc.rep_count = 4'd1;
    #1 reset = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold c%0d: got %b want 00000", c, obs());
      end
    end
    reset = 1'b1;
    ifc.start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 5'b00000) begin
        errors++;
        $display("FAIL reset_release c%0d: got %b want 00000", c, obs());
      end
    end
  endtask

  task automatic test_single();
    logic [29:0] tab;
    logic [4:0]  exp;
    tab = {5'b11010, 5'b01010, 5'b11010, 5'b11110, 5'b00001, 5'b00000};
    ifc.pattern = 4'b1011;
    ifc.rep_count = 4'd1;
    ifc.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      exp = tab[29 - 5*(c-1) -: 5];
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL single c%0d: got %b want %b", c, obs(), exp);
      end
    end
  endtask

  task automatic test_repeat3();
    logic [13:0] xs, vs, fs;
    logic [4:0]  exp;
    xs = 14'b10110101101011;
    vs = 14'b11110111101111;
    fs = 14'b00010000100001;
    ifc.pattern = 4'b1011;
    ifc.rep_count = 4'd3;
    ifc.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      if (c <= 14) exp = {xs[14-c], vs[14-c], fs[14-c], 1'b1, 1'b0};
      else if (c == 15) exp = 5'b00001;
      else exp = 5'b00000;
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL repeat3 c%0d: got %b want %b", c, obs(), exp);
      end
    end
  endtask

  task automatic test_zero();
    logic [4:0] exp;
    ifc.pattern = 4'b1111;
    ifc.rep_count = 4'd0;
    ifc.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      exp = (c == 1) ? 5'b00001 : 5'b00000;
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL zero_rep c%0d: got %b want %b", c, obs(), exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] xs;
    logic [4:0] exp;
    xs = 10'b1011_00_0110;
    ifc.pattern = 4'b1011;
    ifc.rep_count = 4'd1;
    ifc.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 4 || (c >= 7 && c <= 10))
        exp = {xs[10-c], 1'b1, (c == 4 || c == 10), 1'b1, 1'b0};
      else if (c == 5 || c == 11) exp = 5'b00001;
      else exp = 5'b00000;
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL back_to_back c%0d: got %b want %b", c, obs(), exp);
      end
      if (c == 2) ifc.pattern = 4'b0110;
      if (c == 7) ifc.start = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [4:0] exp;
    ifc.pattern = 4'b1011;
    ifc.rep_count = 4'd3;
    ifc.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      exp = (c == 2) ? 5'b01010 : 5'b11010;
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL abort_pre c%0d: got %b want %b", c, obs(), exp);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 5'b00000) begin
      errors++;
      $display("FAIL abort_async: got %b want 00000", obs());
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 5'b00000) begin
        errors++;
        $display("FAIL abort_hold c%0d: got %b want 00000", c, obs());
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 5'b00000) begin
      errors++;
      $display("FAIL abort_no_done: got %b want 00000", obs());
    end
    test_single();
  endtask

  task automatic test_max_repeat();
    int nv = 0, nf = 0, nb = 0, nx = 0, done_at = 0;
    ifc.pattern = 4'b1011;
    ifc.rep_count = 4'd15;
    ifc.start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      nv += int'(ifc.valid);
      nf += int'(ifc.frame_end);
      nb += int'(ifc.busy);
      nx += int'(ifc.x);
      if (ifc.done === 1'b1 && done_at == 0) done_at = c;
    end
    checks++;
    if (nv != 60) begin errors++; $display("FAIL max_valid: got %0d want 60", nv); end
    checks++;
    if (nf != 15) begin errors++; $display("FAIL max_frames: got %0d want 15", nf); end
    checks++;
    if (nb != 74) begin errors++; $display("FAIL max_busy: got %0d want 74", nb); end
    checks++;
    if (nx != 45) begin errors++; $display("FAIL max_ones: got %0d want 45", nx); end
    checks++;
    if (done_at != 75) begin errors++; $display("FAIL max_done_cycle: got %0d want 75", done_at); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat3();
    test_zero();
    test_back_to_back();
    test_abort();
    test_max_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
